// File: rtl/iotdf_round_sched_if.sv
//==============================================================================
// Module  : iotdf_round_sched_if
// Brief   : Requester, config and engine-side signals of the round scheduler.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface iotdf_round_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     gnt;
    logic [NREQ*128-1:0] blk_data;
    logic [NREQ-1:0]     blk_valid;
    logic [NREQ-1:0]     blk_ready;
    logic                cfg_we;
    logic [IDW-1:0]      cfg_id;
    logic [2:0]          cfg_fn;
    logic                eng_busy;
    logic                eng_valid;
    logic [127:0]        eng_out;
    logic                in_en;
    logic [7:0]          iot_in;
    logic [2:0]          fn_sel;
    logic                out_valid;
    logic [127:0]        out_data;
    logic [IDW-1:0]      out_id;

    modport master (
        output req, blk_data, blk_valid, cfg_we, cfg_id, cfg_fn,
               eng_busy, eng_valid, eng_out,
        input  gnt, blk_ready, in_en, iot_in, fn_sel, out_valid, out_data, out_id
    );

    modport slave (
        input  req, blk_data, blk_valid, cfg_we, cfg_id, cfg_fn,
               eng_busy, eng_valid, eng_out,
        output gnt, blk_ready, in_en, iot_in, fn_sel, out_valid, out_data, out_id
    );
endinterface

`default_nettype wire

// File: rtl/iotdf_round_sched.sv
//==============================================================================
// Module  : iotdf_round_sched
// Brief   : Round-robin scheduler sharing one IOTDF engine among NREQ requesters.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module iotdf_round_sched #(
    parameter int NREQ       = 4,
    parameter int ROUND_BLKS = 8,
    parameter int IDW        = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    iotdf_round_sched_if.slave  bus
);
    localparam int               c_BCW      = (ROUND_BLKS > 1) ? $clog2(ROUND_BLKS) : 1;
    localparam logic [c_BCW-1:0] c_LAST_BLK = c_BCW'(ROUND_BLKS - 1);
    localparam logic [IDW-1:0]   c_LAST_ID  = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_ARB  = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_fn [NREQ];
    logic [2:0]       r_fn_sel;
    logic [NREQ-1:0]  r_gnt;
    logic [IDW-1:0]   r_owner;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_out_id;
    logic [c_BCW-1:0] r_blk_cnt;
    logic [3:0]       r_byte_cnt;
    logic [127:0]     r_shift;
    logic             r_seen;

    logic [NREQ-1:0]  w_elig;
    logic [127:0]     w_blk_arr [NREQ];
    logic             w_found;
    logic [IDW-1:0]   w_pick;
    logic [IDW-1:0]   w_idx;
    logic             w_in_en;
    logic [NREQ-1:0]  w_blk_ready;
    logic             w_gap_done;
    logic             w_round_end;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign w_elig[gi]    = bus.req[gi] & (r_fn[gi] != 3'd0);
        assign w_blk_arr[gi] = bus.blk_data[gi*128 +: 128];
    end

    // First eligible requester at or after the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_gap_done  = r_seen & ~bus.eng_busy;
    assign w_round_end = (r_blk_cnt == c_LAST_BLK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_en     = (r_state == S_SEND) & ~bus.eng_busy;
        w_blk_ready = '0;
        case (r_state)
            S_ARB:  if (w_found) w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_blk_ready[r_owner] = 1'b1;
                if (bus.blk_valid[r_owner]) w_state_nxt = S_SEND;
            end
            S_SEND: if (w_in_en && r_byte_cnt == 4'd15) w_state_nxt = S_GAP;
            S_GAP:  if (w_gap_done) w_state_nxt = w_round_end ? S_ARB : S_LOAD;
            default: w_state_nxt = S_ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) r_fn[i] <= 3'd1;
            r_fn_sel   <= 3'd0;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_out_id   <= '0;
            r_blk_cnt  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_seen     <= 1'b0;
        end else begin
            if (bus.cfg_we && (int'(bus.cfg_id) < NREQ)) r_fn[bus.cfg_id] <= bus.cfg_fn;
            case (r_state)
                S_ARB: begin
                    if (w_found) begin
                        r_gnt     <= NREQ'(1) << w_pick;
                        r_fn_sel  <= r_fn[w_pick];
                        r_owner   <= w_pick;
                        r_blk_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    r_seen <= 1'b0;
                    if (bus.blk_valid[r_owner]) begin
                        r_shift    <= w_blk_arr[r_owner];
                        r_byte_cnt <= '0;
                    end
                end
                S_SEND: begin
                    if (w_in_en) begin
                        r_shift    <= {r_shift[119:0], 8'h00};
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                        // Results still in flight keep the previous owner's tag until now
                        if (r_byte_cnt == 4'd0 && r_blk_cnt == '0) r_out_id <= r_owner;
                    end
                end
                S_GAP: begin
                    if (!r_seen) begin
                        if (bus.eng_busy) r_seen <= 1'b1;
                    end else if (!bus.eng_busy) begin
                        r_seen <= 1'b0;
                        if (w_round_end) begin
                            r_gnt <= '0;
                            r_ptr <= (r_owner == c_LAST_ID) ? '0 : r_owner + 1'b1;
                        end else begin
                            r_blk_cnt <= r_blk_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.blk_ready = w_blk_ready;
    assign bus.in_en     = w_in_en;
    assign bus.iot_in    = r_shift[127:120];
    assign bus.fn_sel    = r_fn_sel;
    assign bus.out_valid = bus.eng_valid;
    assign bus.out_data  = bus.eng_out;
    assign bus.out_id    = r_out_id;

endmodule

`default_nettype wire

// File: tb/tb_iotdf_round_sched.sv
//==============================================================================
// Module  : tb_iotdf_round_sched
// Brief   : Directed bench with requester and engine models for iotdf_round_sched.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_iotdf_round_sched;
    localparam int c_NREQ = 4;
    localparam int c_RB   = 8;
    localparam int c_IDW  = 2;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    iotdf_round_sched_if #(.NREQ(c_NREQ), .IDW(c_IDW)) bus ();

    iotdf_round_sched #(.NREQ(c_NREQ), .ROUND_BLKS(c_RB), .IDW(c_IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name, input int got, input int want);
        checks++;
        failures++;
        $display("FAIL %s: timed out, got %0d expected %0d", name, got, want);
    endtask

    // ---------------- requester model ----------------
    logic             uniform;
    logic [3:0]       val_en;
    int               req_n     [c_NREQ];
    int               stall_at  [c_NREQ];
    int               stall_cnt [c_NREQ];

    function automatic logic [127:0] mk_blk(input int i, input int n, input logic uni);
        logic [127:0] b;
        b = '0;
        for (int k = 0; k < 16; k++)
            b[127-8*k -: 8] = uni ? 8'((n % 8) + 1) : 8'(i*64 + (n % 4)*16 + k);
        return b;
    endfunction

    always_comb begin
        bus.blk_data  = '0;
        bus.blk_valid = '0;
        for (int i = 0; i < c_NREQ; i++) begin
            bus.blk_data[i*128 +: 128] = mk_blk(i, req_n[i], uniform);
            bus.blk_valid[i]           = val_en[i] && (stall_cnt[i] == 0);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NREQ; i++) begin
                req_n[i]     <= 0;
                stall_cnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < c_NREQ; i++) begin
                if (bus.blk_valid[i] && bus.blk_ready[i]) begin
                    req_n[i] <= req_n[i] + 1;
                    if (req_n[i] + 1 == stall_at[i]) stall_cnt[i] <= 20;
                end else if (stall_cnt[i] > 0 && bus.blk_ready[i]) begin
                    stall_cnt[i] <= stall_cnt[i] - 1;
                end
            end
        end
    end

    // ---------------- engine model: 1=MAX 2=MIN 3=AVG (bytewise), else MAX ----------------
    int           e_byte, e_blk, busy_cnt, e_nb, e_b, e_an;
    int           acc [16];
    logic [127:0] e_cur, e_now, e_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.eng_busy  <= 1'b0;
            bus.eng_valid <= 1'b0;
            bus.eng_out   <= '0;
            e_byte        <= 0;
            e_blk         <= 0;
            busy_cnt      <= 0;
            e_cur         <= '0;
            for (int k = 0; k < 16; k++) acc[k] <= 0;
        end else begin
            e_nb = (busy_cnt > 0) ? busy_cnt - 1 : 0;
            bus.eng_valid <= 1'b0;
            if (bus.in_en) begin
                e_now = {e_cur[119:0], bus.iot_in};
                e_cur <= e_now;
                if (e_byte == 7) e_nb = 1;
                if (e_byte == 15) begin
                    e_nb   = 3;
                    e_byte <= 0;
                    e_res  = '0;
                    for (int k = 0; k < 16; k++) begin
                        e_b = int'(e_now[127-8*k -: 8]);
                        if (e_blk == 0)              e_an = e_b;
                        else if (bus.fn_sel == 3'd2) e_an = (e_b < acc[k]) ? e_b : acc[k];
                        else if (bus.fn_sel == 3'd3) e_an = acc[k] + e_b;
                        else                         e_an = (e_b > acc[k]) ? e_b : acc[k];
                        acc[k] <= e_an;
                        e_res[127-8*k -: 8] = 8'((bus.fn_sel == 3'd3) ? e_an / c_RB : e_an);
                    end
                    if (e_blk == c_RB - 1) begin
                        bus.eng_valid <= 1'b1;
                        bus.eng_out   <= e_res;
                        e_blk         <= 0;
                    end else begin
                        e_blk <= e_blk + 1;
                    end
                end else begin
                    e_byte <= e_byte + 1;
                end
            end
            busy_cnt     <= e_nb;
            bus.eng_busy <= (e_nb > 0);
        end
    end

    // ---------------- monitor (negedge) ----------------
    logic [127:0] blk_q [$];
    logic [127:0] res_q [$];
    int           rid_q [$];
    int           owners [$];
    int           fnsel_q [$];
    logic [127:0] asm_blk;
    int           asm_cnt, in_en_cnt, wait_cnt;
    int           busy_viol = 0, gnt_viol = 0, fn_viol = 0, wait_viol = 0;
    logic [3:0]   prev_gnt;
    logic [2:0]   round_fn;

    always @(negedge clk) begin
        if (rst) begin
            blk_q.delete(); res_q.delete(); rid_q.delete();
            owners.delete(); fnsel_q.delete();
            asm_cnt = 0; in_en_cnt = 0; wait_cnt = 0;
            prev_gnt = '0;
        end else begin
            for (int i = 0; i < c_NREQ; i++)
                if (bus.blk_valid[i] && bus.blk_ready[i]) blk_q.push_back(bus.blk_data[i*128 +: 128]);
            if (bus.in_en) begin
                if (bus.eng_busy) busy_viol++;
                in_en_cnt++;
                asm_blk = {asm_blk[119:0], bus.iot_in};
                asm_cnt++;
                if (asm_cnt == 16) begin
                    asm_cnt = 0;
                    if (blk_q.size() == 0) check("blk_serial_orphan", asm_blk, 128'hx);
                    else                   check("blk_serial", asm_blk, blk_q.pop_front());
                end
            end
            if (bus.gnt != prev_gnt) begin
                if (prev_gnt != '0 && bus.gnt != '0) gnt_viol++;
                if (bus.gnt != '0) begin
                    if ($countones(bus.gnt) != 1) gnt_viol++;
                    for (int i = 0; i < c_NREQ; i++) if (bus.gnt[i]) owners.push_back(i);
                    fnsel_q.push_back(int'(bus.fn_sel));
                    round_fn = bus.fn_sel;
                end
                prev_gnt = bus.gnt;
            end
            if (bus.gnt != '0 && bus.fn_sel != round_fn) fn_viol++;
            if (bus.blk_ready[0] && !bus.blk_valid[0]) begin
                wait_cnt++;
                if (bus.in_en) wait_viol++;
            end
            if (bus.out_valid) begin
                res_q.push_back(bus.out_data);
                rid_q.push_back(int'(bus.out_id));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst        = 1'b1;
        bus.req    = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_id = '0;
        bus.cfg_fn = '0;
        val_en     = '0;
        uniform    = 1'b0;
        for (int i = 0; i < c_NREQ; i++) stall_at[i] = -1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic cfg_write(input int id, input int fn);
        @(negedge clk);
        bus.cfg_we = 1'b1;
        bus.cfg_id = c_IDW'(id);
        bus.cfg_fn = 3'(fn);
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic wait_owners(input int n, input int budget);
        int c = 0;
        while (owners.size() < n && c < budget) begin @(negedge clk); c++; end
        if (owners.size() < n) timeout("wait_owners", owners.size(), n);
    endtask

    task automatic wait_results(input int n, input int budget);
        int c = 0;
        while (res_q.size() < n && c < budget) begin @(negedge clk); c++; end
        if (res_q.size() < n) timeout("wait_results", res_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (bus.gnt != '0 && c < budget) begin @(negedge clk); c++; end
        if (bus.gnt != '0) timeout("wait_idle", int'(bus.gnt), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},       128'(bus.gnt),       128'h0);
        check({tag, "_blk_ready"}, 128'(bus.blk_ready), 128'h0);
        check({tag, "_in_en"},     128'(bus.in_en),     128'h0);
        check({tag, "_iot_in"},    128'(bus.iot_in),    128'h0);
        check({tag, "_fn_sel"},    128'(bus.fn_sel),    128'h0);
        check({tag, "_out_id"},    128'(bus.out_id),    128'h0);
    endtask

    typedef struct packed {
        logic [3:0]      req;
        logic [3:0][2:0] fn;
        logic [3:0][1:0] exp;
    } vec_t;

    vec_t tv [5];

    initial begin
        tv[0] = '{4'b1011, {3'd1, 3'd1, 3'd1, 3'd1}, {2'd0, 2'd3, 2'd1, 2'd0}};
        tv[1] = '{4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, {2'd3, 2'd2, 2'd1, 2'd0}};
        tv[2] = '{4'b0110, {3'd1, 3'd3, 3'd2, 3'd5}, {2'd2, 2'd1, 2'd2, 2'd1}};
        tv[3] = '{4'b1111, {3'd1, 3'd0, 3'd3, 3'd2}, {2'd0, 2'd3, 2'd1, 2'd0}};
        tv[4] = '{4'b1000, {3'd6, 3'd1, 3'd1, 3'd1}, {2'd3, 2'd3, 2'd3, 2'd3}};

        rst = 1'b1;
        asm_blk = '0;
        // Reset values
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst");
        do_reset();

        // Single requester, MAX over uniform blocks 1..8
        uniform = 1'b1;
        val_en  = 4'b0001;
        bus.req = 4'b0001;
        wait_owners(1, 100);
        bus.req = '0;
        wait_results(1, 2000);
        wait_idle(500);
        check("t1_max_data", res_q[0], {16{8'h08}});
        check("t1_out_id", 128'(rid_q[0]), 128'd0);
        check("t1_in_en_pulses", 128'(in_en_cnt), 128'd128);
        check("t1_rounds", 128'(owners.size()), 128'd1);

        // Arbitration table
        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int i = 0; i < c_NREQ; i++) cfg_write(i, int'(tv[v].fn[i]));
            val_en  = 4'hF;
            bus.req = tv[v].req;
            wait_owners(4, 6000);
            bus.req = '0;
            wait_idle(2000);
            for (int r = 0; r < 4; r++) begin
                check($sformatf("tv%0d_owner%0d", v, r), 128'(owners[r]), 128'(tv[v].exp[r]));
                check($sformatf("tv%0d_fnsel%0d", v, r), 128'(fnsel_q[r]), 128'(tv[v].fn[tv[v].exp[r]]));
            end
        end

        // Disabled requester stays unserved until re-enabled
        do_reset();
        val_en = 4'hF;
        cfg_write(1, 0);
        bus.req = 4'b0010;
        repeat (50) @(negedge clk);
        check("t3_no_grant", 128'(owners.size()), 128'd0);
        check("t3_no_in_en", 128'(in_en_cnt), 128'd0);
        check("t3_gnt_zero", 128'(bus.gnt), 128'h0);
        cfg_write(1, 3);
        wait_owners(1, 100);
        bus.req = '0;
        check("t3_owner", 128'(owners[0]), 128'd1);
        check("t3_fnsel", 128'(fnsel_q[0]), 128'd3);
        wait_idle(2000);

        // 20-cycle valid gap between blocks 3 and 4, AVG
        do_reset();
        uniform     = 1'b1;
        val_en      = 4'b0001;
        stall_at[0] = 3;
        cfg_write(0, 3);
        bus.req = 4'b0001;
        wait_owners(1, 100);
        bus.req = '0;
        wait_results(1, 3000);
        wait_idle(500);
        check("t4_avg_data", res_q[0], {16{8'h04}});
        check("t4_wait_cycles", 128'(wait_cnt), 128'd20);
        check("t4_wait_in_en", 128'(wait_viol), 128'd0);
        check("t4_in_en_pulses", 128'(in_en_cnt), 128'd128);

        // Config write to the owner mid-round applies from the next round
        do_reset();
        val_en  = 4'b0001;
        bus.req = 4'b0001;
        begin
            int c = 0;
            while (req_n[0] < 5 && c < 2000) begin @(negedge clk); c++; end
            if (req_n[0] < 5) timeout("t5_block5", req_n[0], 5);
        end
        cfg_write(0, 2);
        wait_owners(2, 2000);
        bus.req = '0;
        wait_idle(2000);
        check("t5_fnsel_round1", 128'(fnsel_q[0]), 128'd1);
        check("t5_fnsel_round2", 128'(fnsel_q[1]), 128'd2);

        // Reset in the middle of a block
        do_reset();
        val_en  = 4'hF;
        bus.req = 4'b0010;
        wait_owners(1, 100);
        bus.req = '0;
        wait_idle(2000);
        cfg_write(0, 6);
        bus.req = 4'b0100;
        wait_owners(2, 100);
        bus.req = '0;
        begin
            int c = 0;
            while (!(req_n[2] == 2 && e_byte == 9) && c < 2000) begin @(negedge clk); c++; end
            if (!(req_n[2] == 2 && e_byte == 9)) timeout("t6_byte9", e_byte, 9);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6");
        rst = 1'b0;
        @(negedge clk);
        bus.req = 4'hF;
        wait_owners(1, 100);
        bus.req = '0;
        check("t6_ptr_owner", 128'(owners[0]), 128'd0);
        check("t6_fn_reset", 128'(fnsel_q[0]), 128'd1);
        wait_idle(2000);

        check("in_en_while_busy", 128'(busy_viol), 128'd0);
        check("gnt_in_round", 128'(gnt_viol), 128'd0);
        check("fn_sel_in_round", 128'(fn_viol), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
